// File: rtl/div_iter_if.sv
// Execute-stage <-> iterative divider handshake bundle.
// div_by_zero_out exists only when DIV_DBZ_FLAG_EN is defined.
interface div_iter_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 signed_div_in;
   logic [WIDTH-1:0]     opdata1_in;
   logic [WIDTH-1:0]     opdata2_in;
   logic                 start_in;
   logic                 annul_in;
   logic [2*WIDTH-1:0]   result_out;
   logic                 ready_out;
`ifdef DIV_DBZ_FLAG_EN
   logic                 div_by_zero_out;
`endif

   modport master (
      output signed_div_in, opdata1_in, opdata2_in, start_in, annul_in,
      input  result_out, ready_out
`ifdef DIV_DBZ_FLAG_EN
      , input div_by_zero_out
`endif
   );

   modport slave (
      input  signed_div_in, opdata1_in, opdata2_in, start_in, annul_in,
      output result_out, ready_out
`ifdef DIV_DBZ_FLAG_EN
      , output div_by_zero_out
`endif
   );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per clock, result {remainder, quotient}.
// Optional divide-by-zero flag output enabled by defining DIV_DBZ_FLAG_EN.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_iter_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

   state_t               state_q, state_nx;
   logic [CW-1:0]        cnt_q, cnt_nx;
   logic [WIDTH-1:0]     rem_q, rem_nx;
   logic [WIDTH-1:0]     quo_q, quo_nx;
   logic [WIDTH-1:0]     dvs_q, dvs_nx;
   logic                 neg_quo_q, neg_quo_nx;
   logic                 neg_rem_q, neg_rem_nx;
   logic [2*WIDTH-1:0]   result_q, result_nx;
   logic                 ready_q, ready_nx;
`ifdef DIV_DBZ_FLAG_EN
   logic                 dbz_q, dbz_nx;
`endif

   logic                 accept_c, abort_c, last_c, fits_c;
   logic [WIDTH:0]       trial_c;
   logic [WIDTH-1:0]     step_rem_c, step_quo_c, mag_a_c, mag_b_c;

   assign accept_c = bus.start_in && !bus.annul_in;
   assign abort_c  = bus.annul_in || !bus.start_in;
   assign last_c   = (cnt_q == CW'(WIDTH - 1));

   // Operand magnitudes; -2^(W-1) maps onto itself, read back as unsigned 2^(W-1)
   assign mag_a_c = (bus.signed_div_in && bus.opdata1_in[WIDTH-1]) ? -bus.opdata1_in : bus.opdata1_in;
   assign mag_b_c = (bus.signed_div_in && bus.opdata2_in[WIDTH-1]) ? -bus.opdata2_in : bus.opdata2_in;

   // Restoring step: bring the next dividend bit into the remainder, subtract if it fits
   assign trial_c    = {rem_q, quo_q[WIDTH-1]};
   assign fits_c     = (trial_c >= {1'b0, dvs_q});
   assign step_rem_c = fits_c ? WIDTH'(trial_c - {1'b0, dvs_q}) : trial_c[WIDTH-1:0];
   assign step_quo_c = {quo_q[WIDTH-2:0], fits_c};

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      unique case (state_q)
         S_IDLE:   if (accept_c) state_nx = (bus.opdata2_in == '0) ? S_BYZERO : S_ON;
         S_BYZERO: state_nx = S_END;
         S_ON: begin
            if (abort_c)     state_nx = S_IDLE;
            else if (last_c) state_nx = S_END;
         end
         S_END:    if (!bus.start_in) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_nx     = cnt_q;
      rem_nx     = rem_q;
      quo_nx     = quo_q;
      dvs_nx     = dvs_q;
      neg_quo_nx = neg_quo_q;
      neg_rem_nx = neg_rem_q;
      result_nx  = result_q;
      ready_nx   = ready_q;
`ifdef DIV_DBZ_FLAG_EN
      dbz_nx     = dbz_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            result_nx = '0;
            ready_nx  = 1'b0;
`ifdef DIV_DBZ_FLAG_EN
            dbz_nx    = 1'b0;
`endif
            if (accept_c) begin
               cnt_nx     = '0;
               rem_nx     = '0;
               quo_nx     = mag_a_c;
               dvs_nx     = mag_b_c;
               neg_quo_nx = bus.signed_div_in && (bus.opdata1_in[WIDTH-1] ^ bus.opdata2_in[WIDTH-1]);
               neg_rem_nx = bus.signed_div_in && bus.opdata1_in[WIDTH-1];
            end
         end
         S_BYZERO: begin
            result_nx = '0;
            ready_nx  = 1'b1;
`ifdef DIV_DBZ_FLAG_EN
            dbz_nx    = 1'b1;
`endif
         end
         S_ON: begin
            if (!abort_c) begin
               rem_nx = step_rem_c;
               quo_nx = step_quo_c;
               cnt_nx = cnt_q + CW'(1);
               if (last_c) begin
                  result_nx = {neg_rem_q ? -step_rem_c : step_rem_c,
                               neg_quo_q ? -step_quo_c : step_quo_c};
                  ready_nx  = 1'b1;
`ifdef DIV_DBZ_FLAG_EN
                  dbz_nx    = 1'b0;
`endif
               end
            end
         end
         S_END: begin
            if (!bus.start_in) begin
               result_nx = '0;
               ready_nx  = 1'b0;
`ifdef DIV_DBZ_FLAG_EN
               dbz_nx    = 1'b0;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
         dbz_q     <= 1'b0;
`endif
      end else begin
         cnt_q     <= cnt_nx;
         rem_q     <= rem_nx;
         quo_q     <= quo_nx;
         dvs_q     <= dvs_nx;
         neg_quo_q <= neg_quo_nx;
         neg_rem_q <= neg_rem_nx;
         result_q  <= result_nx;
         ready_q   <= ready_nx;
`ifdef DIV_DBZ_FLAG_EN
         dbz_q     <= dbz_nx;
`endif
      end
   end

   assign bus.result_out = result_q;
   assign bus.ready_out  = ready_q;
`ifdef DIV_DBZ_FLAG_EN
   assign bus.div_by_zero_out = dbz_q;
`endif
endmodule

// File: tb/tb_div_iter.sv
// Randomised and directed check of div_iter at WIDTH=32 and WIDTH=8 against an arithmetic model.
// Flag checks follow DIV_DBZ_FLAG_EN.
module tb_div_iter;
   logic clk = 1'b0;
   logic rst;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   div_iter_if #(.WIDTH(32)) b32 ();
   div_iter_if #(.WIDTH(8))  b8 ();

   div_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   div_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Truncating division on w-bit operands, results wrapped to w bits per half
   function automatic logic [63:0] ref_div(input bit sgn, input longint unsigned a,
                                            input longint unsigned b, input int w);
      longint sa, sb, q, r, m;
      m = (longint'(1) << w) - 1;
      if (b == 0) return 64'd0;
      sa = longint'(a);
      sb = longint'(b);
      if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
      if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
      q = sa / sb;
      r = sa % sb;
      return 64'(((r & m) << w) | (q & m));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready32(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!b32.ready_out && n < 100);
   endtask

   task automatic run32(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit hold);
      int n;
      logic [63:0] exp;
      exp = ref_div(sgn, a, b, 32);
      b32.signed_div_in = sgn;
      b32.opdata1_in    = a;
      b32.opdata2_in    = b;
      b32.annul_in      = 1'b0;
      b32.start_in      = 1'b1;
      wait_ready32(n);
      chk({tag, "_lat"}, 64'(n), (b == 0) ? 64'd2 : 64'd33);
      chk({tag, "_res"}, b32.result_out, exp);
`ifdef DIV_DBZ_FLAG_EN
      chk({tag, "_dbz"}, 64'(b32.div_by_zero_out), 64'(b == 0));
`endif
      if (hold) begin
         b32.opdata1_in = ~a;
         b32.opdata2_in = b + 32'd3;
         b32.annul_in   = 1'b1;
         tick();
         tick();
         chk({tag, "_hold_res"}, b32.result_out, exp);
         chk({tag, "_hold_rdy"}, 64'(b32.ready_out), 64'd1);
         b32.annul_in = 1'b0;
      end
      b32.start_in = 1'b0;
      tick();
      chk({tag, "_drop_rdy"}, 64'(b32.ready_out), 64'd0);
      chk({tag, "_drop_res"}, b32.result_out, 64'd0);
`ifdef DIV_DBZ_FLAG_EN
      chk({tag, "_drop_dbz"}, 64'(b32.div_by_zero_out), 64'd0);
`endif
   endtask

   task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b, input string tag);
      int n;
      b8.signed_div_in = sgn;
      b8.opdata1_in    = a;
      b8.opdata2_in    = b;
      b8.annul_in      = 1'b0;
      b8.start_in      = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!b8.ready_out && n < 40);
      chk({tag, "_lat"}, 64'(n), (b == 0) ? 64'd2 : 64'd9);
      chk({tag, "_res"}, 64'(b8.result_out), ref_div(sgn, a, b, 8));
      b8.start_in = 1'b0;
      tick();
      chk({tag, "_drop_rdy"}, 64'(b8.ready_out), 64'd0);
      chk({tag, "_drop_res"}, 64'(b8.result_out), 64'd0);
   endtask

   initial begin
      int n;
      logic [31:0] ra, rb;
      bit rs;
      rst = 1'b0;
      b32.signed_div_in = 1'b0; b32.opdata1_in = '0; b32.opdata2_in = '0;
      b32.start_in = 1'b0; b32.annul_in = 1'b0;
      b8.signed_div_in = 1'b0; b8.opdata1_in = '0; b8.opdata2_in = '0;
      b8.start_in = 1'b0; b8.annul_in = 1'b0;
      tick();
      tick();
      chk("rst_rdy32", 64'(b32.ready_out), 64'd0);
      chk("rst_res32", b32.result_out, 64'd0);
      chk("rst_rdy8", 64'(b8.ready_out), 64'd0);
      chk("rst_res8", 64'(b8.result_out), 64'd0);
`ifdef DIV_DBZ_FLAG_EN
      chk("rst_dbz32", 64'(b32.div_by_zero_out), 64'd0);
`endif
      rst = 1'b1;

      run32(1'b0, 32'd100, 32'd7, "u100_7", 1'b1);
      run32(1'b1, 32'hFFFF_FFF9, 32'd2, "s_m7_2", 1'b0);
      run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf", 1'b0);
      run32(1'b0, 32'h1234, 32'd0, "dbz", 1'b1);
      run32(1'b1, 32'hFFFF_FFFB, 32'd0, "dbz_neg", 1'b0);
      run32(1'b1, 32'd7, 32'hFFFF_FFFE, "s_7_m2", 1'b0);

      // Annul mid-divide: no ready, then a fresh divide completes normally
      b32.signed_div_in = 1'b0; b32.opdata1_in = 32'd123456; b32.opdata2_in = 32'd77;
      b32.start_in = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) tick();
      b32.annul_in = 1'b1;
      tick();
      chk("annul_rdy0", 64'(b32.ready_out), 64'd0);
      b32.annul_in = 1'b0;
      b32.start_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("annul_rdy", 64'(b32.ready_out), 64'd0);
         chk("annul_res", b32.result_out, 64'd0);
      end
      run32(1'b0, 32'd50, 32'd5, "after_annul", 1'b0);

      // Reset mid-divide with start held: restart after release
      b32.signed_div_in = 1'b0; b32.opdata1_in = 32'd1000; b32.opdata2_in = 32'd3;
      b32.start_in = 1'b1;
      tick();
      for (int i = 0; i < 19; i++) tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_rdy", 64'(b32.ready_out), 64'd0);
      chk("mid_rst_res", b32.result_out, 64'd0);
      rst = 1'b1;
      wait_ready32(n);
      chk("mid_rst_lat", 64'(n), 64'd33);
      chk("mid_rst_res2", b32.result_out, {32'd1, 32'd333});
      b32.start_in = 1'b0;
      tick();
      chk("mid_rst_drop", 64'(b32.ready_out), 64'd0);

      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom);
         ra = (($urandom & 7) == 0) ? 32'h8000_0000 : 32'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            3:       rb = 32'($urandom) >> $urandom_range(0, 31);
            default: rb = 32'($urandom);
         endcase
         run32(rs, ra, rb, "rnd32", 1'b0);
      end

      run8(1'b0, 8'd200, 8'd3, "u200_3");
      run8(1'b1, 8'h80, 8'hFF, "s8_ovf");
      run8(1'b0, 8'd55, 8'd0, "dbz8");
      for (int i = 0; i < 20; i++)
         run8(1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), "rnd8");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
